// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified memory port between instruction fetch and the
// memory stage. Only one transaction is in flight at a time; the data
// side normally wins arbitration, but a fetch that has watched MAX_WAIT
// data grants go by is forced through next.

module mem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_req_ready,
  output logic            if_resp_valid,
  output logic [XLEN-1:0] if_rdata,

  input  logic            dm_req_valid,
  input  logic            dm_we,
  input  logic [3:0]      dm_be,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic            dm_req_ready,
  output logic            dm_resp_valid,
  output logic [XLEN-1:0] dm_rdata,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,

  output logic            busy,
  output logic            protocol_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_WAIT);

  logic [1:0]      state;
  logic [3:0]      starve_cnt;

  logic            owner_dm;
  logic            lat_we;
  logic [3:0]      lat_be;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;

  logic            in_idle;
  logic            grant_dm;
  logic            grant_if;
  logic            accept_dm;
  logic            accept_if;
  logic            resp_taken;

  // Arbitration: data side wins unless a pending fetch has hit the starvation limit
  always_comb begin
    in_idle    = (state == ST_IDLE);
    grant_dm   = dm_req_valid && !(if_req_valid && (starve_cnt == STARVE_LIMIT));
    grant_if   = if_req_valid && !grant_dm;
    accept_dm  = in_idle && grant_dm;
    accept_if  = in_idle && grant_if;
    resp_taken = (state == ST_WAIT) && mem_resp_valid;
  end

  assign if_req_ready  = accept_if;
  assign dm_req_ready  = accept_dm;
  assign busy          = !in_idle;

  assign mem_req_valid = (state == ST_REQ);
  assign mem_we        = lat_we;
  assign mem_be        = lat_be;
  assign mem_addr      = lat_addr;
  assign mem_wdata     = lat_wdata;

  // Transaction sequencing: accept in IDLE, hold the request in REQ, await the reply in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept_dm || accept_if) state <= ST_REQ;
        ST_REQ:  if (mem_req_ready)          state <= ST_WAIT;
        ST_WAIT: if (mem_resp_valid)         state <= ST_IDLE;
        default:                             state <= ST_IDLE;
      endcase
    end
  end

  // Capture the winner's request so the memory side sees a stable payload until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= 4'h0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept_dm) begin
      owner_dm  <= 1'b1;
      lat_we    <= dm_we;
      lat_be    <= dm_be;
      lat_addr  <= dm_addr;
      lat_wdata <= dm_wdata;
    end else if (accept_if) begin
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= 4'hF;
      lat_addr  <= if_addr;
      lat_wdata <= '0;
    end
  end

  // Count data grants that overtook a waiting fetch; only meaningful while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (in_idle) begin
      if (accept_dm && if_req_valid) begin
        if (starve_cnt != STARVE_LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else if (accept_if || !if_req_valid) begin
        starve_cnt <= 4'd0;
      end
    end
  end

  // Route the memory reply to its owner as a one-cycle pulse; store acks leave dm_rdata alone
  always_ff @(posedge clk) begin
    if (rst) begin
      if_resp_valid <= 1'b0;
      dm_resp_valid <= 1'b0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
    end else begin
      if_resp_valid <= 1'b0;
      dm_resp_valid <= 1'b0;
      if (resp_taken) begin
        if (owner_dm) begin
          dm_resp_valid <= 1'b1;
          if (!lat_we) dm_rdata <= mem_rdata;
        end else begin
          if_resp_valid <= 1'b1;
          if_rdata      <= mem_rdata;
        end
      end
    end
  end

  // A reply with nothing outstanding is dropped and flagged until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err <= 1'b0;
    end else if (mem_resp_valid && (state != ST_WAIT)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the arbiter and a word-addressed memory.

module tb_mem_port_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic            clk;
  logic            rst;
  logic            if_req_valid;
  logic [XLEN-1:0] if_addr;
  logic            if_req_ready;
  logic            if_resp_valid;
  logic [XLEN-1:0] if_rdata;
  logic            dm_req_valid;
  logic            dm_we;
  logic [3:0]      dm_be;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_req_ready;
  logic            dm_resp_valid;
  logic [XLEN-1:0] dm_rdata;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_rdata;
  logic            busy;
  logic            protocol_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] last_if_data;
  logic [31:0] last_dm_data;

  logic [31:0] mem_model [logic [31:0]];

  mem_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .dm_req_valid(dm_req_valid), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_req_ready(dm_req_ready), .dm_resp_valid(dm_resp_valid),
    .dm_rdata(dm_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .protocol_err(protocol_err)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never settles
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic idle_inputs();
    if_req_valid   = 1'b0;
    if_addr        = '0;
    dm_req_valid   = 1'b0;
    dm_we          = 1'b0;
    dm_be          = 4'h0;
    dm_addr        = '0;
    dm_wdata       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_if_data = '0;
    last_dm_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({busy, mem_req_valid, if_req_ready, dm_req_ready, if_resp_valid, dm_resp_valid, protocol_err} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {busy, mem_req_valid, if_req_ready, dm_req_ready, if_resp_valid, dm_resp_valid, protocol_err});
    end
    checks++;
    if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'd0) begin
      failures++;
      $display("[TB] FAIL reset_mem_payload: got %h expected 0", {mem_we, mem_be, mem_addr, mem_wdata});
    end
    checks++;
    if ({if_rdata, dm_rdata} !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_rdata: got %h expected 0", {if_rdata, dm_rdata});
    end
    @(negedge clk);
    rst = 1'b0;
    last_if_data = '0;
    last_dm_data = '0;
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 32'h100; mem_req_ready = 1'b1;
    #1;
    checks++;
    if ({if_req_ready, dm_req_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL lone_ready: got %b expected 10", {if_req_ready, dm_req_ready});
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      failures++;
      $display("[TB] FAIL lone_mem_req: got %h expected %h",
               {mem_req_valid, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
    end
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 32'h0050_0093;
    #1;
    checks++;
    if ({mem_req_valid, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL lone_wait: got %b expected 01", {mem_req_valid, busy});
    end
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({if_resp_valid, dm_resp_valid, busy, if_rdata} !== {3'b100, 32'h0050_0093}) begin
      failures++;
      $display("[TB] FAIL lone_resp: got %h expected %h",
               {if_resp_valid, dm_resp_valid, busy, if_rdata}, {3'b100, 32'h0050_0093});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({if_resp_valid, if_rdata} !== {1'b0, 32'h0050_0093}) begin
      failures++;
      $display("[TB] FAIL lone_hold: got %h expected %h", {if_resp_valid, if_rdata}, {1'b0, 32'h0050_0093});
    end
    last_if_data = 32'h0050_0093;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 32'h104;
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2000;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if ({if_req_ready, dm_req_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL simul_grant: got %b expected 01", {if_req_ready, dm_req_ready});
    end
    @(negedge clk);
    dm_req_valid = 1'b0;
    #1;
    checks++;
    if ({if_req_ready, mem_req_valid, mem_addr} !== {2'b01, 32'h2000}) begin
      failures++;
      $display("[TB] FAIL simul_dm_issue: got %h expected %h", {if_req_ready, mem_req_valid, mem_addr}, {2'b01, 32'h2000});
    end
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 32'h1122_3344;
    #1;
    checks++;
    if (if_req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simul_if_blocked: got %b expected 0", if_req_ready);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = '0;
    #1;
    checks++;
    if ({dm_resp_valid, dm_rdata, if_req_ready} !== {1'b1, 32'h1122_3344, 1'b1}) begin
      failures++;
      $display("[TB] FAIL simul_dm_resp_if_accept: got %h expected %h",
               {dm_resp_valid, dm_rdata, if_req_ready}, {1'b1, 32'h1122_3344, 1'b1});
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h104}) begin
      failures++;
      $display("[TB] FAIL simul_if_issue: got %h expected %h", {mem_req_valid, mem_addr}, {1'b1, 32'h104});
    end
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_AAAA;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    checks++;
    if ({if_resp_valid, if_rdata} !== {1'b1, 32'h0000_AAAA}) begin
      failures++;
      $display("[TB] FAIL simul_if_resp: got %h expected %h", {if_resp_valid, if_rdata}, {1'b1, 32'h0000_AAAA});
    end
    last_if_data = 32'h0000_AAAA;
    last_dm_data = 32'h1122_3344;
  endtask

  task automatic test_starvation();
    logic [15:0] exp_order;
    logic [15:0] got_order;
    logic        both_seen;
    int          cnt;
    int          grants;
    int          cyc;
    exp_order = '0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt == MAX_WAIT) begin
        exp_order[k] = 1'b1;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    got_order = '0;
    both_seen = 1'b0;
    grants = 0;
    cyc = 0;
    while (grants < 10 && cyc < 200) begin
      @(negedge clk);
      if_req_valid = 1'b1; if_addr = 32'h200;
      dm_req_valid = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h3000;
      mem_req_ready = 1'b1; mem_rdata = 32'h5A5A_0001;
      mem_resp_valid = busy && !mem_req_valid;
      #1;
      if (if_req_ready && dm_req_ready) both_seen = 1'b1;
      if (if_req_ready) begin got_order[grants] = 1'b1; grants++; end
      else if (dm_req_ready) begin grants++; end
      cyc++;
    end
    checks++;
    if (grants !== 10) begin
      failures++;
      $display("[TB] FAIL starve_grant_count: got %0d expected 10", grants);
    end
    checks++;
    if (got_order !== exp_order) begin
      failures++;
      $display("[TB] FAIL starve_order (1=IF): got %b expected %b", got_order, exp_order);
    end
    checks++;
    if (both_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL starve_both_ready: got %b expected 0", both_seen);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if_req_valid = 1'b0; dm_req_valid = 1'b0; mem_req_ready = 1'b1;
      mem_resp_valid = busy && !mem_req_valid;
    end
    idle_inputs();
    last_if_data = 32'h5A5A_0001;
    last_dm_data = 32'h5A5A_0001;
  endtask

  task automatic test_store();
    @(negedge clk);
    dm_req_valid = 1'b1; dm_we = 1'b1; dm_be = 4'b0011;
    dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; mem_req_ready = 1'b0;
    #1;
    checks++;
    if (dm_req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL store_accept: got %b expected 1", dm_req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dm_req_valid = 1'b0; dm_we = 1'b0; dm_be = 4'hC;
      dm_addr = 32'h0BAD_0000 + 32'(k); dm_wdata = 32'h1234_0000 + 32'(k);
      mem_req_ready = (k == 3);
      #1;
      checks++;
      if ({mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF}) begin
        failures++;
        $display("[TB] FAIL store_stable_%0d: got %h expected %h", k,
                 {mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata},
                 {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF});
      end
    end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h9999_9999;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL store_wait: got %b expected 0", mem_req_valid);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    checks++;
    if ({dm_resp_valid, if_resp_valid, dm_rdata} !== {2'b10, last_dm_data}) begin
      failures++;
      $display("[TB] FAIL store_ack: got %h expected %h", {dm_resp_valid, if_resp_valid, dm_rdata}, {2'b10, last_dm_data});
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 32'h300; mem_req_ready = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if ({busy, mem_req_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL midrst_in_wait: got %b expected 10", {busy, mem_req_valid});
    end
    @(negedge clk);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    checks++;
    if ({busy, mem_req_valid, if_req_ready, dm_req_ready, if_resp_valid, dm_resp_valid, protocol_err} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL midrst_flags: got %b expected 0000000",
               {busy, mem_req_valid, if_req_ready, dm_req_ready, if_resp_valid, dm_resp_valid, protocol_err});
    end
    checks++;
    if ({mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata} !== 133'd0) begin
      failures++;
      $display("[TB] FAIL midrst_data: got %h expected 0", {mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    checks++;
    if ({protocol_err, if_resp_valid, dm_resp_valid, if_rdata} !== {3'b100, 32'h0}) begin
      failures++;
      $display("[TB] FAIL midrst_late_resp: got %h expected %h", {protocol_err, if_resp_valid, dm_resp_valid, if_rdata}, {3'b100, 32'h0});
    end
    last_if_data = '0;
    last_dm_data = '0;
  endtask

  task automatic test_spurious();
    apply_reset();
    @(negedge clk);
    #1;
    checks++;
    if (protocol_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL spur_clear: got %b expected 0", protocol_err);
    end
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    checks++;
    if ({protocol_err, if_resp_valid, dm_resp_valid, if_rdata, dm_rdata} !== {3'b100, 64'h0}) begin
      failures++;
      $display("[TB] FAIL spur_set: got %h expected %h", {protocol_err, if_resp_valid, dm_resp_valid, if_rdata, dm_rdata}, {3'b100, 64'h0});
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({protocol_err, if_resp_valid, dm_resp_valid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL spur_sticky: got %b expected 100", {protocol_err, if_resp_valid, dm_resp_valid});
    end
  endtask

  task automatic test_random();
    logic        iv, dv;
    logic        outst, mem_acc, pulse_due, pulse_dm;
    logic        t_dm, t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wdata;
    logic        dm_win, exp_if_rdy, exp_dm_rdy, resp_now;
    logic [31:0] resp_data;
    logic [31:0] word;
    int          starve;
    apply_reset();
    mem_model.delete();
    iv = 1'b0; dv = 1'b0; outst = 1'b0; mem_acc = 1'b0; pulse_due = 1'b0; pulse_dm = 1'b0;
    t_dm = 1'b0; t_we = 1'b0; t_be = '0; t_addr = '0; t_wdata = '0; starve = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (iv && $urandom_range(0, 9) == 0) iv = 1'b0;
      else if (!iv && $urandom_range(0, 1) == 1) begin
        iv = 1'b1;
        if_addr = 32'h100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (dv && $urandom_range(0, 9) == 0) dv = 1'b0;
      else if (!dv && $urandom_range(0, 1) == 1) begin
        dv = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_be    = 4'($urandom);
        dm_addr  = 32'h2000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        dm_wdata = $urandom;
      end
      if_req_valid  = iv;
      dm_req_valid  = dv;
      mem_req_ready = ($urandom_range(0, 9) < 6);
      resp_now = outst && mem_acc && ($urandom_range(0, 1) == 1);
      resp_data = t_we ? $urandom : mem_read(t_addr);
      mem_resp_valid = resp_now;
      mem_rdata = resp_now ? resp_data : $urandom;
      #1;
      dm_win     = dv && !(iv && starve == MAX_WAIT);
      exp_if_rdy = !outst && iv && !dm_win;
      exp_dm_rdy = !outst && dm_win;
      checks++;
      if ({if_req_ready, dm_req_ready} !== {exp_if_rdy, exp_dm_rdy}) begin
        failures++;
        $display("[TB] FAIL rnd_ready cyc %0d: got %b expected %b", cyc, {if_req_ready, dm_req_ready}, {exp_if_rdy, exp_dm_rdy});
      end
      checks++;
      if ({busy, mem_req_valid} !== {outst, outst && !mem_acc}) begin
        failures++;
        $display("[TB] FAIL rnd_busy_req cyc %0d: got %b expected %b", cyc, {busy, mem_req_valid}, {outst, outst && !mem_acc});
      end
      if (outst && !mem_acc) begin
        checks++;
        if ({mem_we, mem_be, mem_addr} !== {t_we, t_be, t_addr}) begin
          failures++;
          $display("[TB] FAIL rnd_payload cyc %0d: got %h expected %h", cyc, {mem_we, mem_be, mem_addr}, {t_we, t_be, t_addr});
        end
        if (t_we) begin
          checks++;
          if (mem_wdata !== t_wdata) begin
            failures++;
            $display("[TB] FAIL rnd_wdata cyc %0d: got %h expected %h", cyc, mem_wdata, t_wdata);
          end
        end
      end
      checks++;
      if ({if_resp_valid, dm_resp_valid} !== {pulse_due && !pulse_dm, pulse_due && pulse_dm}) begin
        failures++;
        $display("[TB] FAIL rnd_resp cyc %0d: got %b expected %b", cyc, {if_resp_valid, dm_resp_valid},
                 {pulse_due && !pulse_dm, pulse_due && pulse_dm});
      end
      checks++;
      if ({if_rdata, dm_rdata} !== {last_if_data, last_dm_data}) begin
        failures++;
        $display("[TB] FAIL rnd_rdata cyc %0d: got %h expected %h", cyc, {if_rdata, dm_rdata}, {last_if_data, last_dm_data});
      end
      checks++;
      if (protocol_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rnd_protocol_err cyc %0d: got %b expected 0", cyc, protocol_err);
      end
      if (!outst) begin
        if (exp_dm_rdy && iv) starve = (starve < MAX_WAIT) ? starve + 1 : MAX_WAIT;
        else if (exp_if_rdy || !iv) starve = 0;
      end
      pulse_due = 1'b0;
      if (resp_now) begin
        outst = 1'b0;
        pulse_due = 1'b1;
        pulse_dm = t_dm;
        if (!t_dm) last_if_data = resp_data;
        else if (!t_we) last_dm_data = resp_data;
        else begin
          word = mem_read(t_addr);
          for (int b = 0; b < 4; b++) if (t_be[b]) word[8*b +: 8] = t_wdata[8*b +: 8];
          mem_model[t_addr] = word;
        end
      end else if (outst && !mem_acc && mem_req_ready) begin
        mem_acc = 1'b1;
      end
      if (exp_if_rdy) begin
        outst = 1'b1; mem_acc = 1'b0;
        t_dm = 1'b0; t_we = 1'b0; t_be = 4'hF; t_addr = if_addr; t_wdata = '0;
        iv = 1'b0;
      end else if (exp_dm_rdy) begin
        outst = 1'b1; mem_acc = 1'b0;
        t_dm = 1'b1; t_we = dm_we; t_be = dm_be; t_addr = dm_addr; t_wdata = dm_wdata;
        dv = 1'b0;
      end
    end
    idle_inputs();
  endtask

  // Scenario sequence
  initial begin
    rst = 1'b1;
    idle_inputs();
    last_if_data = '0;
    last_dm_data = '0;
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
